// File: rtl/gtob_conv_arbiter_pkg.sv
// gtob_conv_arbiter_pkg
//   Shared defaults for the Gray-to-binary conversion arbiter and a
//   constant-function log2 used to size the requester ID.
package gtob_conv_arbiter_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_NREQ  = 4;
  localparam int unsigned DEF_CNT_W = 16;

  // Ceiling log2, never below 1 so a 1-bit ID always exists.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/gtob_conv_arbiter_if.sv
// gtob_conv_arbiter_if
//   Bundles the requester side and the result side of the arbiter.
//   req_valid/req_gray/req_ready : NREQ requesters, Gray code i at [i*WIDTH +: WIDTH]
//   out_valid/out_ready/out_bin/out_id : single registered result slot
//   done_cnt : count of completed output handshakes
//   slave  : the arbiter itself
//   master : the environment (requesters + downstream consumer)
interface gtob_conv_arbiter_if
  import gtob_conv_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned CNT_W = DEF_CNT_W
);
  localparam int unsigned ID_W = clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_gray;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_bin;
  logic [ID_W-1:0]       out_id;
  logic [CNT_W-1:0]      done_cnt;

  modport master (
    output req_valid, req_gray, out_ready,
    input  req_ready, out_valid, out_bin, out_id, done_cnt
  );

  modport slave (
    input  req_valid, req_gray, out_ready,
    output req_ready, out_valid, out_bin, out_id, done_cnt
  );

endinterface

// File: rtl/gtob_conv_arbiter_gray2bin_core.sv
// gray2bin_core
//   Combinational WIDTH-bit Gray-to-binary conversion.
//   gray : Gray-coded input
//   bin  : binary result, bin[k] = XOR of gray[WIDTH-1:k]
module gray2bin_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Each bit is the parity of all Gray bits at or above it, which unrolls
  // the bin[k] = bin[k+1] ^ gray[k] chain without a self-referencing vector.
  always_comb begin
    bin = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      bin[k] = ^(gray >> k);
    end
  end

endmodule

// File: rtl/gtob_conv_arbiter.sv
// gtob_conv_arbiter
//   Round-robin arbiter sharing one Gray-to-binary converter among NREQ
//   requesters, feeding a single registered result slot with backpressure
//   and counting completed output handshakes.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : gtob_conv_arbiter_if slave (requests, result slot, done_cnt)
module gtob_conv_arbiter
  import gtob_conv_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NREQ  = DEF_NREQ,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  gtob_conv_arbiter_if.slave bus
);

  localparam int unsigned ID_W = clog2(NREQ);

  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  gidx;
  logic [NREQ-1:0]  grant;
  logic             accept;
  logic             slot_free;
  logic             drain;
  logic [WIDTH-1:0] sel_gray;
  logic [WIDTH-1:0] sel_bin;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_bin_q;
  logic [ID_W-1:0]  out_id_q;
  logic [CNT_W-1:0] cnt_q;

  assign slot_free = !out_valid_q || bus.out_ready;
  assign drain     = out_valid_q && bus.out_ready;

  // Search from ptr upward modulo NREQ; first valid requester wins.
  // rst_n gates the search so no grant is visible while reset is held.
  always_comb begin
    int unsigned idx;
    grant    = '0;
    gidx     = '0;
    accept   = 1'b0;
    sel_gray = '0;
    idx      = 0;
    if (rst_n && slot_free) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        idx = (32'(ptr) + k) % NREQ;
        if (!accept && bus.req_valid[idx]) begin
          accept      = 1'b1;
          grant[idx]  = 1'b1;
          gidx        = ID_W'(idx);
          sel_gray    = bus.req_gray[idx*WIDTH +: WIDTH];
        end
      end
    end
  end

  gray2bin_core #(.WIDTH(WIDTH)) u_gray2bin (
    .gray (sel_gray),
    .bin  (sel_bin)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= '0;
      out_valid_q <= 1'b0;
      out_bin_q   <= '0;
      out_id_q    <= '0;
      cnt_q       <= '0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_bin_q   <= sel_bin;
        out_id_q    <= gidx;
        ptr         <= (gidx == ID_W'(NREQ - 1)) ? '0 : gidx + 1'b1;
      end else if (drain) begin
        out_valid_q <= 1'b0;
      end
      if (drain) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.req_ready = grant;
  assign bus.out_valid = out_valid_q;
  assign bus.out_bin   = out_bin_q;
  assign bus.out_id    = out_id_q;
  assign bus.done_cnt  = cnt_q;

endmodule

// File: tb/tb_gtob_conv_arbiter.sv
// tb_gtob_conv_arbiter
//   Scoreboard bench for gtob_conv_arbiter. A reference arbitration model
//   predicts grants each cycle; accepted conversions are pushed to a queue
//   and popped when the DUT completes the output handshake. CNT_W is
//   narrowed so done_cnt wrap-around is reached.
module tb_gtob_conv_arbiter;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned ID_W  = 2;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [WIDTH-1:0] bin;
  } exp_t;

  logic clk;
  logic rst_n;

  gtob_conv_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .CNT_W(CNT_W)) bus ();

  gtob_conv_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  exp_t        sb[$];
  int unsigned glog[$];
  int unsigned m_ptr = 0;
  bit          m_ov  = 0;
  int unsigned m_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Prefix-XOR by doubling shifts: independent of the DUT's bitwise parity form.
  function automatic logic [WIDTH-1:0] ref_g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = g;
    for (int s = 1; s < int'(WIDTH); s = s * 2) b = b ^ (b >> s);
    return b;
  endfunction

  task automatic set_req(input int unsigned i, input logic v, input logic [WIDTH-1:0] g);
    bus.req_valid[i]                = v;
    bus.req_gray[i*WIDTH +: WIDTH] = g;
  endtask

  task automatic model_reset();
    sb.delete();
    m_ptr = 0;
    m_ov  = 0;
    m_cnt = 0;
  endtask

  // Called just after a negedge with inputs settled; ends at the next negedge.
  task automatic step();
    logic [NREQ-1:0] eg;
    int unsigned     gi;
    bit              acc;
    exp_t            e;
    #1;
    eg  = '0;
    acc = 0;
    gi  = 0;
    if (!m_ov || bus.out_ready) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        int unsigned j;
        j = (m_ptr + k) % NREQ;
        if (!acc && bus.req_valid[j]) begin
          acc   = 1;
          gi    = j;
          eg[j] = 1'b1;
        end
      end
    end
    for (int unsigned k = 0; k < NREQ; k++)
      if (bus.req_ready[k]) glog.push_back(k);
    check_eq("req_ready", 32'(bus.req_ready), 32'(eg));
    check_eq("done_cnt", 32'(bus.done_cnt), m_cnt);
    check_eq("out_valid", 32'(bus.out_valid), 32'(m_ov));
    if (m_ov) begin
      check_eq("sb_depth", sb.size(), 1);
      if (sb.size() > 0) begin
        check_eq("out_bin", 32'(bus.out_bin), 32'(sb[0].bin));
        check_eq("out_id", 32'(bus.out_id), 32'(sb[0].id));
        if (bus.out_ready) begin
          void'(sb.pop_front());
          m_cnt = (m_cnt + 1) % (1 << CNT_W);
        end
      end
    end
    if (acc) begin
      e.id  = ID_W'(gi);
      e.bin = ref_g2b(bus.req_gray[gi*WIDTH +: WIDTH]);
      sb.push_back(e);
      m_ptr = (gi + 1) % NREQ;
      m_ov  = 1;
    end else if (m_ov && bus.out_ready) begin
      m_ov = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int unsigned exp2 [5];
    int unsigned n0, n3;
    exp2 = '{0, 1, 2, 3, 0};

    // Reset state, with requests present to show req_ready is forced low.
    rst_n         = 1'b0;
    bus.req_valid = '1;
    bus.req_gray  = '0;
    bus.out_ready = 1'b1;
    #2;
    check_eq("rst_out_valid", 32'(bus.out_valid), 0);
    check_eq("rst_out_bin", 32'(bus.out_bin), 0);
    check_eq("rst_out_id", 32'(bus.out_id), 0);
    check_eq("rst_done_cnt", 32'(bus.done_cnt), 0);
    check_eq("rst_req_ready", 32'(bus.req_ready), 0);
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single requester 1, gray 0110 -> bin 0100.
    set_req(1, 1'b1, 4'b0110);
    bus.out_ready = 1'b1;
    step();
    check_eq("t1_bin", 32'(bus.out_bin), 32'h4);
    check_eq("t1_id", 32'(bus.out_id), 1);
    set_req(1, 1'b0, '0);
    step();
    check_eq("t1_cnt", 32'(bus.done_cnt), 1);

    // 2: all four valid from reset, grants 0,1,2,3,0 back to back.
    pulse_reset();
    glog.delete();
    set_req(0, 1'b1, 4'b0000);
    set_req(1, 1'b1, 4'b0011);
    set_req(2, 1'b1, 4'b0111);
    set_req(3, 1'b1, 4'b1100);
    for (int i = 0; i < 5; i++) begin
      step();
      if (i > 0) check_eq("t2_no_bubble", 32'(bus.out_valid), 1);
    end
    check_eq("t2_grants", glog.size(), 5);
    for (int i = 0; i < 5 && i < glog.size(); i++)
      check_eq("t2_grant_seq", glog[i], exp2[i]);
    bus.req_valid = '0;
    step();

    // 3: backpressure with gray 1000 (bin 1111) held in the slot.
    set_req(1, 1'b1, 4'b1000);
    step();
    bus.out_ready = 1'b0;
    bus.req_valid = '1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("t3_hold_bin", 32'(bus.out_bin), 32'hF);
    end
    bus.out_ready = 1'b1;
    step();
    bus.req_valid = '0;
    step();
    step();

    // 4: requester 2 sweeps Gray-count order; done_cnt wraps at CNT_W=4.
    for (int unsigned k = 0; k < 16; k++) begin
      set_req(2, 1'b1, WIDTH'(k ^ (k >> 1)));
      step();
      check_eq("t4_seq_bin", 32'(bus.out_bin), k);
    end
    bus.req_valid = '0;
    step();

    // 5: requesters 0 and 3 continuously valid for 20 cycles.
    glog.delete();
    set_req(0, 1'b1, 4'b0101);
    set_req(3, 1'b1, 4'b1010);
    for (int i = 0; i < 20; i++) step();
    n0 = 0;
    n3 = 0;
    foreach (glog[i]) begin
      if (glog[i] == 0) n0++;
      if (glog[i] == 3) n3++;
    end
    check_eq("t5_grants0", n0, 10);
    check_eq("t5_grants3", n3, 10);
    for (int i = 1; i < glog.size(); i++)
      check_eq("t5_alternate", glog[i], (glog[i-1] == 0) ? 3 : 0);
    bus.req_valid = '0;
    step();

    // 6: async reset while a stalled result is pending.
    bus.out_ready = 1'b0;
    set_req(2, 1'b1, 4'b0001);
    step();
    set_req(0, 1'b1, 4'b0100);
    step();
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", 32'(bus.out_valid), 0);
    check_eq("t6_rst_cnt", 32'(bus.done_cnt), 0);
    check_eq("t6_rst_ready", 32'(bus.req_ready), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check_eq("t6_tie", 32'(bus.req_ready), 32'h1);
    step();
    check_eq("t6_tie_id", 32'(bus.out_id), 0);
    bus.req_valid = '0;
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
